// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and response bus of alu_cmd_sequencer
interface alu_cmd_sequencer_if #(
    parameter int SEQ_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [2:0]       cmd_op;

    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [2:0]       alu_op;
    logic [7:0]       alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic [2:0]       rsp_op;
    logic [SEQ_W-1:0] rsp_seq;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_seq
    );

    // Producer / ALU / consumer side
    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_seq
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - FIFO-buffered command front-end for the 8-bit alu (optional ALU_SEQ_STATS_EN adds rsp_count)
module alu_cmd_sequencer #(
    parameter  int DEPTH = 4,
    parameter  int SEQ_W = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_sequencer_if.master bus,
    output logic [LVL_W-1:0]  fifo_level
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]       rsp_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [7:0]       mem_a  [DEPTH];
    logic [7:0]       mem_b  [DEPTH];
    logic [2:0]       mem_op [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    logic [7:0]       alu_a_q;
    logic [7:0]       alu_b_q;
    logic [2:0]       alu_op_q;
    logic [7:0]       rsp_result_q;
    logic [2:0]       rsp_op_q;
    logic [SEQ_W-1:0] rsp_seq_q;

    logic             push;
    logic             pop;
    logic             load;
    logic             rsp_fire;
    logic             not_empty;

    // Ready depends on the current level only, so a full FIFO never admits a push even if it pops this cycle
    assign bus.cmd_ready  = (level < LVL_W'(DEPTH));
    assign push           = bus.cmd_valid && bus.cmd_ready;
    assign not_empty      = (level != '0);
    assign bus.rsp_valid  = (state == RESP);
    assign rsp_fire       = bus.rsp_valid && bus.rsp_ready;
    assign fifo_level     = level;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_seq    = rsp_seq_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus load/pop strobes; the head is popped in ISSUE so RESP already sees the next command
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (not_empty) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                pop        = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (not_empty) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command storage; contents need no reset because the level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= bus.cmd_a;
            mem_b[wr_ptr]  <= bus.cmd_b;
            mem_op[wr_ptr] <= bus.cmd_op;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ALU operand registers change only on a load so the ALU sees stable inputs through ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else if (load) begin
            alu_a_q  <= mem_a[rd_ptr];
            alu_b_q  <= mem_b[rd_ptr];
            alu_op_q <= mem_op[rd_ptr];
        end
    end

    // Response capture at the end of ISSUE; the tag advances only on a completed handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_seq_q    <= '0;
        end else begin
            if (pop) begin
                rsp_result_q <= bus.alu_result;
                rsp_op_q     <= alu_op_q;
            end
            if (rsp_fire) begin
                rsp_seq_q <= rsp_seq_q + 1'b1;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    // Saturating count of completed responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_count <= '0;
        end else if (rsp_fire && (rsp_count != 16'hFFFF)) begin
            rsp_count <= rsp_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int SEQ_W = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [LVL_W-1:0] fifo_level;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]      rsp_count;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_seq  = 0;
    int   n_rsp    = 0;
    cmd_t model_q[$];
    cmd_t item;
    logic       hold_valid = 1'b0;
    logic [7:0] hold_result;
    logic [2:0] hold_op;
    logic [SEQ_W-1:0] hold_seq;

    alu_cmd_sequencer_if #(.SEQ_W(SEQ_W)) bus ();

    alu_cmd_sequencer #(
        .DEPTH(DEPTH),
        .SEQ_W(SEQ_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level)
`ifdef ALU_SEQ_STATS_EN
        ,
        .rsp_count  (rsp_count)
`endif
    );

    // External combinational ALU
    assign bus.alu_result = (bus.alu_op == 3'b000) ? bus.alu_a + bus.alu_b :
                            (bus.alu_op == 3'b001) ? bus.alu_a - bus.alu_b : 8'h00;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_result(cmd_t c);
        case (c.op)
            3'd0:    return (int'(c.a) + int'(c.b)) % 256;
            3'd1:    return (int'(c.a) - int'(c.b) + 256) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic rdy;
        int   budget;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        budget = 0;
        do begin
            rdy = bus.cmd_ready;
            tick();
            budget++;
        end while (!rdy && budget < 200);
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic clear_model();
        model_q.delete();
        exp_seq    = 0;
        n_rsp      = 0;
        hold_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        clear_model();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        int budget;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        budget = 0;
        while ((model_q.size() != 0 || bus.rsp_valid) && budget < 200) begin
            tick();
            budget++;
        end
        chk("drain_left", model_q.size(), 0);
        bus.rsp_ready = 1'b0;
    endtask

    // Reference model: records accepted commands and checks every response handshake in order
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("hold_valid",  bus.rsp_valid,  1);
                chk("hold_result", bus.rsp_result, hold_result);
                chk("hold_op",     bus.rsp_op,     hold_op);
                chk("hold_seq",    bus.rsp_seq,    hold_seq);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                item.a  = bus.cmd_a;
                item.b  = bus.cmd_b;
                item.op = bus.cmd_op;
                model_q.push_back(item);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (model_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    item = model_q.pop_front();
                    chk("rsp_result", bus.rsp_result, ref_result(item));
                    chk("rsp_op",     bus.rsp_op,     item.op);
                    chk("rsp_seq",    bus.rsp_seq,    exp_seq % (1 << SEQ_W));
                end
                exp_seq++;
                n_rsp++;
            end
            hold_valid  = bus.rsp_valid && !bus.rsp_ready;
            hold_result = bus.rsp_result;
            hold_op     = bus.rsp_op;
            hold_seq    = bus.rsp_seq;
        end
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) tick();

        // Reset values
        chk("rst_cmd_ready",  bus.cmd_ready,  1);
        chk("rst_level",      fifo_level,     0);
        chk("rst_rsp_valid",  bus.rsp_valid,  0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_op",     bus.rsp_op,     0);
        chk("rst_rsp_seq",    bus.rsp_seq,    0);
        chk("rst_alu_a",      bus.alu_a,      0);
        chk("rst_alu_b",      bus.alu_b,      0);
        chk("rst_alu_op",     bus.alu_op,     0);
`ifdef ALU_SEQ_STATS_EN
        chk("rst_rsp_count",  rsp_count,      0);
`endif
        rst = 1'b0;
        tick();

        // Single ADD: load at N+1, response from N+2
        send(8'd5, 8'd3, 3'b000);
        chk("lat_n0_valid", bus.rsp_valid, 0);
        tick();
        chk("lat_n1_valid", bus.rsp_valid, 0);
        chk("lat_n1_alu_a", bus.alu_a, 5);
        chk("lat_n1_alu_b", bus.alu_b, 3);
        chk("lat_n1_alu_op", bus.alu_op, 0);
        tick();
        chk("lat_n2_valid",  bus.rsp_valid,  1);
        chk("lat_n2_result", bus.rsp_result, 8);
        chk("lat_n2_op",     bus.rsp_op,     0);
        chk("lat_n2_seq",    bus.rsp_seq,    0);
        chk("lat_n2_level",  fifo_level,     0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("lat_done_valid", bus.rsp_valid, 0);
        chk("lat_alu_hold",   bus.alu_a,     5);
        chk("lat_seq_inc",    bus.rsp_seq,   1);

        // Back-to-back SUBs, one response every 2 cycles
        do_reset();
        bus.rsp_ready = 1'b1;
        send(8'd9, 8'd2, 3'b001);
        send(8'd3, 8'd5, 3'b001);
        tick();
        chk("b2b_v0",   bus.rsp_valid,  1);
        chk("b2b_r0",   bus.rsp_result, 7);
        chk("b2b_s0",   bus.rsp_seq,    0);
        tick();
        chk("b2b_gap",  bus.rsp_valid,  0);
        tick();
        chk("b2b_v1",   bus.rsp_valid,  1);
        chk("b2b_r1",   bus.rsp_result, 8'hFE);
        chk("b2b_s1",   bus.rsp_seq,    1);
        tick();
        chk("b2b_end",  bus.rsp_valid,  0);
        bus.rsp_ready = 1'b0;

        // Back-pressure: 1 in RESP plus DEPTH queued fills the FIFO
        do_reset();
        for (int i = 0; i < 5; i++) send(8'(i * 10 + 1), 8'(i), 3'b000);
        chk("bp_ready",  bus.cmd_ready,  0);
        chk("bp_level",  fifo_level,     4);
        chk("bp_valid",  bus.rsp_valid,  1);
        chk("bp_result", bus.rsp_result, 1);
        bus.cmd_a = 8'hAA; bus.cmd_b = 8'h55; bus.cmd_op = 3'b000;
        bus.cmd_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("bp_full_ready", bus.cmd_ready, 0);
            chk("bp_full_level", fifo_level,    4);
        end
        bus.cmd_valid = 1'b0;
        begin
            int budget = 0;
            bus.rsp_ready = 1'b1;
            while (n_rsp < 5 && budget < 50) begin
                tick();
                budget++;
            end
        end
        tick();
        chk("bp_drained", n_rsp,       5);
        chk("bp_seq",     bus.rsp_seq, 5);
        chk("bp_level0",  fifo_level,  0);
        chk("bp_alu_last", bus.alu_a,  41);
        bus.rsp_ready = 1'b0;

        // Wrap and pass-through opcode
        do_reset();
        bus.rsp_ready = 1'b1;
        send(8'd200, 8'd100, 3'b000);
        tick();
        tick();
        chk("wrap_valid",  bus.rsp_valid,  1);
        chk("wrap_result", bus.rsp_result, 8'h2C);
        tick();
        send(8'd7, 8'd7, 3'b101);
        tick();
        tick();
        chk("pass_valid",  bus.rsp_valid,  1);
        chk("pass_result", bus.rsp_result, 0);
        chk("pass_op",     bus.rsp_op,     3'b101);
        tick();
        bus.rsp_ready = 1'b0;

        // Asynchronous reset while in RESP with 2 queued
        do_reset();
        send(8'd1, 8'd1, 3'b000);
        send(8'd2, 8'd2, 3'b000);
        send(8'd3, 8'd3, 3'b000);
        chk("ar_pre_valid", bus.rsp_valid, 1);
        chk("ar_pre_level", fifo_level,    2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid",  bus.rsp_valid, 0);
        chk("ar_level",  fifo_level,    0);
        chk("ar_ready",  bus.cmd_ready, 1);
        chk("ar_result", bus.rsp_result, 0);
        clear_model();
        repeat (2) tick();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (8) begin
            tick();
            chk("ar_no_stale", bus.rsp_valid, 0);
        end
        bus.rsp_ready = 1'b0;

        // 17 responses: tag wraps to 1
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(8'($urandom), 8'($urandom), 3'b000);
        drain();
        chk("seq_wrap", bus.rsp_seq, 1);
        chk("seq_wrap_n", n_rsp, 17);
`ifdef ALU_SEQ_STATS_EN
        chk("stats_17", rsp_count, 17);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_a     = 8'($urandom);
            bus.cmd_b     = 8'($urandom);
            bus.cmd_op    = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
            chk("rand_level_max", (fifo_level <= DEPTH), 1);
        end
        drain();
        tick();
        chk("rand_seq", bus.rsp_seq, exp_seq % (1 << SEQ_W));
        chk("rand_idle_level", fifo_level, 0);
`ifdef ALU_SEQ_STATS_EN
        chk("rand_count", rsp_count, n_rsp);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Registered command front-end that sits directly upstream of the combinational 8-bit `alu`. It accepts (a, b, op) commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand inputs from registers, captures the ALU result one cycle later, and returns it with a sequence tag over a second valid/ready handshake. This lets producers stream ALU operations without managing ALU settle time or back-pressure.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO depth; power of two, at least 2.
- `SEQ_W`, 4: width of the response sequence tag.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_a`, `cmd_b`  in  8  operands.
- `cmd_op`  in  3  ALU opcode: 000 = ADD, 001 = SUB, all others pass through.
- `alu_a`, `alu_b`  out  8  registered operands to the ALU.
- `alu_op`  out  3  registered opcode to the ALU.
- `alu_result`  in  8  combinational ALU output.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  8  captured ALU result.
- `rsp_op`  out  3  opcode that produced `rsp_result`.
- `rsp_seq`  out  `SEQ_W`  issue-order tag; 0 after reset, +1 per response, wraps modulo 2^`SEQ_W`.
- `fifo_level`  out  $clog2(`DEPTH`+1)  number of queued commands.

## Operation
- Handshakes:
  - A command is pushed when `cmd_valid && cmd_ready`.
  - `cmd_ready = (fifo_level < DEPTH)`. It is computed from the current level only, so a pop in the same cycle does not admit a push when full.
  - A response completes when `rsp_valid && rsp_ready`.
- FIFO: circular buffer with read/write pointers and a level counter. Simultaneous push and pop leaves the level unchanged. Pointers wrap at `DEPTH`.
- FSM states IDLE, ISSUE, RESP:
  - IDLE: if FIFO non-empty, load `alu_a`/`alu_b`/`alu_op` from the FIFO head, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: capture `alu_result` into `rsp_result` and `alu_op` into `rsp_op`, pop the FIFO head, then go to RESP.
  - RESP: `rsp_valid = 1`.
    - On `rsp_ready`: increment `rsp_seq`. If the FIFO is non-empty, load the ALU registers from the head and go to ISSUE; otherwise go to IDLE.
    - Without `rsp_ready`: hold every response output stable.
- `alu_*` registers change only on a load; otherwise they retain their last value.
- Opcodes other than 000/001 are not checked. Whatever the ALU returns (0x00) is forwarded.
- Arithmetic is done entirely by the ALU. The block adds no width extension, and 8-bit wrap is passed through unchanged.

## Timing
- Reset values:
  - `cmd_ready` = 1, `fifo_level` = 0, `rsp_valid` = 0.
  - `rsp_result` = 0, `rsp_op` = 0, `rsp_seq` = 0.
  - `alu_a` = `alu_b` = 0, `alu_op` = 0.
  - State IDLE, pointers 0.
- Latency from an idle block:
  - Command pushed at edge N.
  - ALU registers loaded at edge N+1.
  - Result captured at edge N+2; `rsp_valid` is high from N+2.
- Throughput: one response per 2 cycles with `rsp_ready` held high and the FIFO non-empty.
- The ALU inputs are stable for the full ISSUE cycle before capture, so the combinational path is `alu_*` regs -> ALU -> `rsp_result` reg.
- Reset asserted mid-operation: the FIFO is flushed and any in-flight or pending response is discarded. Outputs go to their reset values immediately (asynchronously), not at the next edge.
- `rsp_valid` never deasserts without a handshake, except on reset.

## Configuration
- Macro `ALU_SEQ_STATS_EN`.
- Defined: adds output `rsp_count` (out, 16), reset 0. It increments on every response handshake and saturates at 0xFFFF.
- Undefined: the `rsp_count` port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then push ADD a=5 b=3 -> `rsp_valid` at cycle +2 with `rsp_result` = 8, `rsp_op` = 000, `rsp_seq` = 0.
- Push SUB 9,2 then SUB 3,5 back-to-back with `rsp_ready` = 1 -> results 7 (seq 0) then 0xFE (seq 1), 2 cycles apart.
- `rsp_ready` = 0, push 5 ADD commands (DEPTH=4) -> `cmd_ready` drops to 0 once `fifo_level` = 4 (1 command captured into RESP, 4 queued). `rsp_result` is held stable throughout. Releasing `rsp_ready` drains all 5 in order with seq 0..4.
- ADD 200,100 -> 0x2C (wrap). op=101 with a=7, b=7 -> `rsp_result` = 0x00, `rsp_op` = 101.
- Assert `rst` while in RESP with 2 commands queued -> `rsp_valid` = 0 and `fifo_level` = 0 immediately. No stale response appears after release.
- With `ALU_SEQ_STATS_EN`, 17 responses -> `rsp_count` = 17, and `rsp_seq` = 1 (wrapped, SEQ_W=4).
